// File: rtl/float_to_double.sv
// Exact IEEE-754 single-to-double widening converter with stb/ack handshakes on both ports.
// Optional build macro FLUSH_SUBNORMAL_EN: subnormal inputs become signed zero instead of being normalised.
module float_to_double (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [63:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack,
  output logic [2:0]  o_state
);

  // Handshake: a word moves on a rising edge where both stb and ack are
  // sampled high; stb holds its data stable until that edge, and ack/stb
  // seen outside the owning state are ignored.
  typedef enum logic [2:0] {
    GET_A     = 3'd0,
    UNPACK    = 3'd1,
`ifndef FLUSH_SUBNORMAL_EN
    NORMALISE = 3'd2,
    PACK      = 3'd3,
`endif
    PUT_Z     = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_a;
  logic [63:0] r_z;
  logic [63:0] r_output_z;
  logic        r_input_a_ack;
  logic        r_output_z_stb;
  logic [7:0]  w_e8;
  logic [22:0] w_f;
  logic        w_subnormal;
`ifndef FLUSH_SUBNORMAL_EN
  logic [23:0] r_m;
  logic [10:0] r_e;
`endif

  assign w_e8         = r_a[30:23];
  assign w_f          = r_a[22:0];
  assign w_subnormal  = (w_e8 == 8'd0) && (w_f != 23'd0);
  assign input_a_ack  = r_input_a_ack;
  assign output_z     = r_output_z;
  assign output_z_stb = r_output_z_stb;
  assign o_state      = r_state;

  always_ff @(posedge clk) begin
    if (rst) r_state <= GET_A;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      GET_A:     if (r_input_a_ack && input_a_stb) w_next = UNPACK;
`ifndef FLUSH_SUBNORMAL_EN
      UNPACK:    w_next = w_subnormal ? NORMALISE : PUT_Z;
      NORMALISE: if (r_m[23]) w_next = PACK;
      PACK:      w_next = PUT_Z;
`else
      UNPACK:    w_next = PUT_Z;
`endif
      PUT_Z:     if (r_output_z_stb && output_z_ack) w_next = GET_A;
      default:   w_next = GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_input_a_ack  <= 1'b0;
      r_output_z_stb <= 1'b0;
    end else begin
      case (r_state)
        GET_A: begin
          r_input_a_ack <= 1'b1;
          if (r_input_a_ack && input_a_stb) begin
            r_a           <= input_a;
            r_input_a_ack <= 1'b0;
          end
        end
        UNPACK: begin
          r_z[63] <= r_a[31];
          if (w_e8 == 8'd0 && w_f == 23'd0) begin
            r_z[62:0] <= 63'd0;
          end else if (w_subnormal) begin
`ifdef FLUSH_SUBNORMAL_EN
            r_z[62:0] <= 63'd0;
`else
            r_m <= {1'b0, w_f};
            // 897 = 1023 - 126, so the first shift lands on the 2^-127 scale.
            r_e <= 11'd897;
`endif
          end else if (w_e8 == 8'hFF) begin
            r_z[62:52] <= 11'h7FF;
            r_z[28:0]  <= 29'd0;
            if (w_f == 23'd0) r_z[51:29] <= 23'd0;
            else              r_z[51:29] <= {1'b1, w_f[21:0]};
          end else begin
            r_z[62:52] <= {3'b000, w_e8} + 11'd896;
            r_z[51:29] <= w_f;
            r_z[28:0]  <= 29'd0;
          end
        end
`ifndef FLUSH_SUBNORMAL_EN
        NORMALISE: begin
          if (!r_m[23]) begin
            r_m <= {r_m[22:0], 1'b0};
            r_e <= r_e - 11'd1;
          end
        end
        PACK: begin
          r_z[62:52] <= r_e;
          r_z[51:29] <= r_m[22:0];
          r_z[28:0]  <= 29'd0;
        end
`endif
        PUT_Z: begin
          r_output_z_stb <= 1'b1;
          r_output_z     <= r_z;
          if (r_output_z_stb && output_z_ack) r_output_z_stb <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_double.sv
// Self-checking bench for float_to_double: directed cases, backpressure, mid-run reset
// and a randomised back-to-back scoreboard run against an independent reference model.
module tb_float_to_double;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_a = 32'd0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [63:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;
  logic [2:0]  o_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];

  float_to_double dut (
    .clk(clk), .rst(rst),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack),
    .o_state(o_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: decode the value, locate the leading one, re-encode.
  function automatic logic [63:0] ref_conv(input logic [31:0] a);
    logic [7:0]  e;
    logic [22:0] f;
    logic [63:0] tmp;
    int p;
    e = a[30:23];
    f = a[22:0];
    if (e == 8'd0 && f == 23'd0) return {a[31], 63'd0};
    if (e == 8'd0) begin
`ifdef FLUSH_SUBNORMAL_EN
      return {a[31], 63'd0};
`else
      p = 0;
      for (int i = 0; i < 23; i++) if (f[i]) p = i;
      tmp = {41'd0, f} << (52 - p);
      return {a[31], 11'(p + 874), tmp[51:0]};
`endif
    end
    if (e == 8'hFF) begin
      if (f == 23'd0) return {a[31], 11'h7FF, 52'd0};
      return {a[31], 11'h7FF, 1'b1, f[21:0], 29'd0};
    end
    return {a[31], 11'(int'(e) - 127 + 1023), f, 29'd0};
  endfunction

  task automatic drive_op(input logic [31:0] v, input int gap, output int acc_c);
    int n;
    acc_c = -1;
    repeat (gap) begin @(posedge clk); #1; end
    input_a = v;
    input_a_stb = 1'b1;
    exp_q.push_back(ref_conv(v));
    n = 0;
    while (input_a_ack !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL accept_timeout: input_a_ack never rose for operand %h", v);
    end else begin
      @(posedge clk); #1;
      acc_c = cyc;
    end
    input_a_stb = 1'b0;
  endtask

  task automatic receive_one(input int hold, input string nm, output int stb_c);
    int n;
    logic [63:0] got, expv;
    stb_c = -1;
    n = 0;
    while (output_z_stb !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s_timeout: output_z_stb never rose", nm);
      return;
    end
    stb_c = cyc;
    got = output_z;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected: output %h with empty queue", nm, got);
    end else begin
      expv = exp_q.pop_front();
      if (got !== expv) begin
        errors++;
        $display("FAIL %s_value: got %h expected %h", nm, got, expv);
      end
    end
    repeat (hold) begin
      @(posedge clk); #1;
      checks++;
      if (output_z_stb !== 1'b1 || output_z !== got || input_a_ack !== 1'b0) begin
        errors++;
        $display("FAIL %s_hold: stb=%b z=%h ack=%b expected stb=1 z=%h ack=0",
                 nm, output_z_stb, output_z, input_a_ack, got);
      end
    end
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    checks++;
    if (output_z_stb !== 1'b0) begin
      errors++;
      $display("FAIL %s_drop: output_z_stb=%b expected 0 after accept", nm, output_z_stb);
    end
  endtask

  task automatic run_directed(input logic [31:0] v, input int lat, input string nm);
    int acc_c, stb_c;
    drive_op(v, 0, acc_c);
    receive_one(0, nm, stb_c);
    checks++;
    if (stb_c - acc_c !== lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges expected %0d", nm, stb_c - acc_c, lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (input_a_ack !== 1'b0 || output_z_stb !== 1'b0 || o_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: ack=%b stb=%b state=%0d expected 0 0 0",
               input_a_ack, output_z_stb, o_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_specials();
    run_directed(32'h3F800000, 2, "one");
    run_directed(32'hC0200000, 2, "neg_2p5");
    run_directed(32'h80000000, 2, "neg_zero");
    run_directed(32'h7F800000, 2, "pos_inf");
    run_directed(32'h7FC00001, 2, "qnan");
    run_directed(32'hFF800123, 2, "snan");
  endtask

  task automatic test_subnormal();
`ifdef FLUSH_SUBNORMAL_EN
    run_directed(32'h00000001, 2, "sub_min");
    run_directed(32'h00400000, 2, "sub_half");
`else
    run_directed(32'h00000001, 27, "sub_min");
    run_directed(32'h00400000, 5, "sub_half");
`endif
  endtask

  task automatic test_backpressure();
    int acc_c, stb_c;
    drive_op(32'h40490FDB, 0, acc_c);
    receive_one(10, "backpressure", stb_c);
    @(posedge clk); #1;
    checks++;
    if (input_a_ack !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_reack: input_a_ack=%b expected 1", input_a_ack);
    end
  endtask

  task automatic test_early_ack();
    int acc_c, n;
    logic [63:0] expv;
    output_z_ack = 1'b1;
    drive_op(32'hBE200000, 0, acc_c);
    n = 0;
    while (output_z_stb !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    expv = exp_q.pop_front();
    checks++;
    if (output_z_stb !== 1'b1 || output_z !== expv) begin
      errors++;
      $display("FAIL early_ack_value: stb=%b z=%h expected stb=1 z=%h", output_z_stb, output_z, expv);
    end
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    checks++;
    if (output_z_stb !== 1'b0) begin
      errors++;
      $display("FAIL early_ack_drop: stb=%b expected 0", output_z_stb);
    end
  endtask

  task automatic test_reset_midrun();
    int acc_c, seen;
    drive_op(32'h00000001, 0, acc_c);
`ifndef FLUSH_SUBNORMAL_EN
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (o_state !== 3'd2) begin
      errors++;
      $display("FAIL midrun_state: state=%0d expected 2", o_state);
    end
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if (input_a_ack !== 1'b0 || output_z_stb !== 1'b0) begin
      errors++;
      $display("FAIL midrun_after_rst: ack=%b stb=%b expected 0 0", input_a_ack, output_z_stb);
    end
    @(posedge clk); #1;
    checks++;
    if (input_a_ack !== 1'b1) begin
      errors++;
      $display("FAIL midrun_reack: input_a_ack=%b expected 1", input_a_ack);
    end
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (output_z_stb) seen++; end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midrun_no_output: stb high %0d cycles expected 0", seen);
    end
    run_directed(32'h3F800000, 2, "after_rst");
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    logic [22:0] f;
    case ($urandom_range(0, 3))
      0: begin
        v = $urandom;
        v[30:23] = 8'($urandom_range(1, 254));
      end
      1: begin
        f = 23'($urandom_range(1, 23'h7FFFFF) >> $urandom_range(0, 22));
        if (f == 23'd0) f = 23'd1;
        v = {1'($urandom_range(0, 1)), 8'd0, f};
      end
      2: v = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(0, 3) == 0 ? 0 : $urandom)};
      default: v = {1'($urandom_range(0, 1)), 31'd0};
    endcase
    return v;
  endfunction

  task automatic test_back_to_back();
    int n_ops = 40;
    int seen;
    fork
      begin
        int acc_c;
        for (int i = 0; i < n_ops; i++) drive_op(rand_operand(), $urandom_range(0, 3), acc_c);
      end
      begin
        int stb_c;
        for (int j = 0; j < n_ops; j++) receive_one($urandom_range(0, 4), "b2b", stb_c);
      end
    join
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (output_z_stb) seen++; end
    checks++;
    if (seen !== 0 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_leftover: extra stb cycles %0d, queue left %0d, expected 0 0", seen, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_specials();
    test_subnormal();
    test_backpressure();
    test_early_ack();
    test_reset_midrun();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
